frogger_traffic_ctrl: RTL and testbench
=======================================

// Module: frogger_traffic_ctrl
// PURPOSE
//  Sequences the moving road objects and the countdown timer for the frogger renderer.
//  Once per video frame it advances the firetruck, bus and motorcycle X positions, with
//  wrap-around at the screen edge, and decrements the green time-bar width.
//  Its outputs feed the renderer's object X coordinates and time-bar width directly.
//  An IDLE/RUN/PAUSED/TIMEOUT state machine gates all motion.
// PARAMETERS
//  SCREEN_W    640  horizontal wrap modulus; all X outputs stay in [0, SCREEN_W-1]
//  FT_INIT_X   440  firetruck X after reset/start
//  BUS_INIT_X  440  bus X after reset/start
//  MC_INIT_X   440  motorcycle X after reset/start
//  FT_SPEED    2    firetruck pixels per move tick, moving left (1..SCREEN_W-1)
//  BUS_SPEED   1    bus pixels per move tick, moving right (1..SCREEN_W-1)
//  MC_SPEED    3    motorcycle pixels per move tick, moving left (1..SCREEN_W-1)
//  MOVE_DIV    1    frames per move tick (>=1)
//  TIME_INIT   200  time-bar width loaded on reset/start/frog_home (1..255)
//  TIME_DIV    30   frames per time-bar decrement (>=1)
// PORTS
//  Clk          in   1   system clock; all state updates on the rising edge
//  Reset        in   1   synchronous reset, active-low (0 = reset)
//  frame_clk    in   1   vsync-derived level, synchronous to Clk; its rising edge marks a frame
//  start        in   1   one-cycle pulse: (re)initialise and enter RUN
//  pause        in   1   one-cycle pulse: toggle between RUN and PAUSED
//  frog_home    in   1   one-cycle pulse: reload the time bar to TIME_INIT (RUN/PAUSED only)
//  firetruckX   out  10  firetruck left X
//  busX         out  10  bus left X
//  motorcycleX  out  10  motorcycle left X
//  time_width   out  8   time-bar width in pixels
//  time_up      out  1   high while in TIMEOUT
//  running      out  1   high while in RUN
// BEHAVIOUR
//  Reset (Reset==0 at the edge):
//  - state=IDLE; X outputs = *_INIT_X; time_width=TIME_INIT; time_up=0; running=0.
//  - Frame edge register and both divider counters are cleared to 0.
//  Reset has priority over all other inputs and is honoured mid-operation.
//  Frame tick:
//  - frame_d <= frame_clk every cycle.
//  - tick = frame_clk & ~frame_d, so tick is high for exactly 1 Clk per frame.
//  Dividers, advanced only on tick in RUN:
//  - mv_cnt counts 0..MOVE_DIV-1; a move tick occurs when mv_cnt==MOVE_DIV-1, then mv_cnt wraps to 0.
//  - tm_cnt counts 0..TIME_DIV-1 the same way to produce a time tick.
//  - Both counters hold their value in PAUSED.
//  Motion on a move tick. Outputs update at the same edge; visible 1 cycle after tick.
//  - Left movers: X <= (X < SPD) ? X + SCREEN_W - SPD : X - SPD.
//  - Right mover (bus): X <= (X + SPD >= SCREEN_W) ? X + SPD - SCREEN_W : X + SPD.
//  - Use 11-bit intermediates; no result ever reaches SCREEN_W.
//  Time bar on a time tick:
//  - If time_width > 1: decrement by 1.
//  - If time_width == 1: set it to 0 and enter TIMEOUT at the same edge.
//  State machine:
//  - IDLE: start -> RUN (reload all). Other inputs are ignored.
//  - RUN: pause -> PAUSED. Time bar reaches 0 -> TIMEOUT.
//  - PAUSED: pause -> RUN. No motion and no countdown while PAUSED.
//  - TIMEOUT: objects frozen; time_width=0; time_up=1. start -> RUN (reload all).
//  - "Reload all" means: X outputs = *_INIT_X, time_width=TIME_INIT, both counters = 0.
//  Simultaneous events:
//  - start beats pause, frog_home and tick in the same cycle: reload only, no motion.
//  - frog_home together with a time tick: the reload wins (time_width=TIME_INIT); tm_cnt still resets to 0.
//  - pause together with a tick in RUN: enter PAUSED; that tick is discarded.
//  - frog_home while in PAUSED reloads the time bar; frog_home in IDLE or TIMEOUT is ignored.
// TESTING
//  1. Reset low for 2 cycles -> IDLE, X=440/440/440, time_width=200, time_up=0, running=0.
//  2. start, then 1 frame edge (MOVE_DIV=1) -> firetruckX=438, busX=441, motorcycleX=437 one cycle after the tick.
//  3. Wrap: force firetruckX=1, then move tick -> 639. Bus at 639, then move tick -> 0. Motorcycle at 2, then move tick -> 639.
//  4. TIME_DIV=30: after 30 ticks time_width=199; frog_home -> 200. With time_width=1 and a time tick -> 0, time_up=1, X frozen over 5 further frames.
//  5. pause in RUN, then 10 frames -> X and time_width unchanged; pause again -> motion resumes on the next tick.
//  6. start and tick in the same cycle, and a reset asserted mid-RUN -> both give exactly the reload/reset values, with no motion applied.

Source files
------------

// File: rtl/frogger_traffic_ctrl.sv
// Frogger traffic controller: once per video frame moves the three road objects
// (with screen wrap) and counts the time bar down. An IDLE/RUN/PAUSED/TIMEOUT
// state machine gates all motion and countdown.
module frogger_traffic_ctrl #(
   parameter int SCREEN_W   = 640,
   parameter int FT_INIT_X  = 440,
   parameter int BUS_INIT_X = 440,
   parameter int MC_INIT_X  = 440,
   parameter int FT_SPEED   = 2,
   parameter int BUS_SPEED  = 1,
   parameter int MC_SPEED   = 3,
   parameter int MOVE_DIV   = 1,
   parameter int TIME_INIT  = 200,
   parameter int TIME_DIV   = 30
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic       start,
   input  logic       pause,
   input  logic       frog_home,
   output logic [9:0] firetruckX,
   output logic [9:0] busX,
   output logic [9:0] motorcycleX,
   output logic [7:0] time_width,
   output logic       time_up,
   output logic       running
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2, TIMEOUT = 2'd3} state_t;

   localparam int MV_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
   localparam int TM_W = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
   localparam logic [10:0] SCREEN_W11 = 11'(SCREEN_W);
   localparam logic [MV_W-1:0] MV_LAST = MV_W'(MOVE_DIV - 1);
   localparam logic [TM_W-1:0] TM_LAST = TM_W'(TIME_DIV - 1);

   state_t            state_q, state_d;
   logic              frame_q, frame_d;
   logic [MV_W-1:0]   mv_cnt_q, mv_cnt_d;
   logic [TM_W-1:0]   tm_cnt_q, tm_cnt_d;
   logic [9:0]        ft_x_q, ft_x_d;
   logic [9:0]        bus_x_q, bus_x_d;
   logic [9:0]        mc_x_q, mc_x_d;
   logic [7:0]        time_q, time_d;
   logic              tick;

   // Leftward step with wrap; 11-bit math keeps X + SCREEN_W - SPD from overflowing.
   function automatic logic [9:0] move_left(input logic [9:0] x, input logic [10:0] spd);
      logic [10:0] w;
      w = {1'b0, x};
      if (w < spd) w = w + SCREEN_W11 - spd;
      else         w = w - spd;
      return w[9:0];
   endfunction

   // Rightward step with wrap at the screen edge.
   function automatic logic [9:0] move_right(input logic [9:0] x, input logic [10:0] spd);
      logic [10:0] w;
      w = {1'b0, x} + spd;
      if (w >= SCREEN_W11) w = w - SCREEN_W11;
      return w[9:0];
   endfunction

   assign tick = frame_clk & ~frame_q;

   // Next-state, divider, motion and time-bar logic; everything holds by default.
   always_comb begin
      state_d  = state_q;
      frame_d  = frame_clk;
      mv_cnt_d = mv_cnt_q;
      tm_cnt_d = tm_cnt_q;
      ft_x_d   = ft_x_q;
      bus_x_d  = bus_x_q;
      mc_x_d   = mc_x_q;
      time_d   = time_q;
      if (start) begin
         // start wins over every other input in every state: reload only.
         state_d  = RUN;
         mv_cnt_d = '0;
         tm_cnt_d = '0;
         ft_x_d   = 10'(FT_INIT_X);
         bus_x_d  = 10'(BUS_INIT_X);
         mc_x_d   = 10'(MC_INIT_X);
         time_d   = 8'(TIME_INIT);
      end else begin
         case (state_q)
            RUN: begin
               if (frog_home) time_d = 8'(TIME_INIT);
               if (pause) begin
                  // A tick arriving with pause is dropped.
                  state_d = PAUSED;
               end else if (tick) begin
                  if (mv_cnt_q == MV_LAST) begin
                     mv_cnt_d = '0;
                     ft_x_d   = move_left(ft_x_q, 11'(FT_SPEED));
                     bus_x_d  = move_right(bus_x_q, 11'(BUS_SPEED));
                     mc_x_d   = move_left(mc_x_q, 11'(MC_SPEED));
                  end else begin
                     mv_cnt_d = mv_cnt_q + 1'b1;
                  end
                  if (tm_cnt_q == TM_LAST) begin
                     tm_cnt_d = '0;
                     // frog_home reload takes precedence over the decrement.
                     if (!frog_home) begin
                        if (time_q > 8'd1) begin
                           time_d = time_q - 8'd1;
                        end else begin
                           time_d  = 8'd0;
                           state_d = TIMEOUT;
                        end
                     end
                  end else begin
                     tm_cnt_d = tm_cnt_q + 1'b1;
                  end
               end
            end
            PAUSED: begin
               if (frog_home) time_d = 8'(TIME_INIT);
               if (pause) state_d = RUN;
            end
            default: ;  // IDLE and TIMEOUT wait for start
         endcase
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q  <= IDLE;
         frame_q  <= 1'b0;
         mv_cnt_q <= '0;
         tm_cnt_q <= '0;
         ft_x_q   <= 10'(FT_INIT_X);
         bus_x_q  <= 10'(BUS_INIT_X);
         mc_x_q   <= 10'(MC_INIT_X);
         time_q   <= 8'(TIME_INIT);
      end else begin
         state_q  <= state_d;
         frame_q  <= frame_d;
         mv_cnt_q <= mv_cnt_d;
         tm_cnt_q <= tm_cnt_d;
         ft_x_q   <= ft_x_d;
         bus_x_q  <= bus_x_d;
         mc_x_q   <= mc_x_d;
         time_q   <= time_d;
      end
   end

   assign firetruckX  = ft_x_q;
   assign busX        = bus_x_q;
   assign motorcycleX = mc_x_q;
   assign time_width  = time_q;
   assign time_up     = (state_q == TIMEOUT);
   assign running     = (state_q == RUN);

endmodule

// File: tb/tb_frogger_traffic_ctrl.sv
// Directed bench for frogger_traffic_ctrl. Instance a uses the default
// parameters; instance b starts near the screen edges with a 3-tick time bar
// so wrap-around and timeout are reached in a few frames. Both share stimulus.
module tb_frogger_traffic_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_clk = 1'b0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic       frog_home = 1'b0;

   logic [9:0] a_ft, a_bus, a_mc, b_ft, b_bus, b_mc;
   logic [7:0] a_tw, b_tw;
   logic       a_up, a_run, b_up, b_run;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   frogger_traffic_ctrl u_a (
      .Clk(clk), .Reset(rst_n), .frame_clk(frame_clk), .start(start), .pause(pause),
      .frog_home(frog_home), .firetruckX(a_ft), .busX(a_bus), .motorcycleX(a_mc),
      .time_width(a_tw), .time_up(a_up), .running(a_run)
   );

   frogger_traffic_ctrl #(
      .FT_INIT_X(1), .BUS_INIT_X(639), .MC_INIT_X(2), .TIME_INIT(3), .TIME_DIV(1)
   ) u_b (
      .Clk(clk), .Reset(rst_n), .frame_clk(frame_clk), .start(start), .pause(pause),
      .frog_home(frog_home), .firetruckX(b_ft), .busX(b_bus), .motorcycleX(b_mc),
      .time_width(b_tw), .time_up(b_up), .running(b_run)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input int ft, input int bus, input int mc,
                        input int tw, input int up, input int run);
      chk({tag, ".a_ft"}, int'(a_ft), ft);
      chk({tag, ".a_bus"}, int'(a_bus), bus);
      chk({tag, ".a_mc"}, int'(a_mc), mc);
      chk({tag, ".a_tw"}, int'(a_tw), tw);
      chk({tag, ".a_up"}, int'(a_up), up);
      chk({tag, ".a_run"}, int'(a_run), run);
   endtask

   task automatic chk_b(input string tag, input int ft, input int bus, input int mc,
                        input int tw, input int up, input int run);
      chk({tag, ".b_ft"}, int'(b_ft), ft);
      chk({tag, ".b_bus"}, int'(b_bus), bus);
      chk({tag, ".b_mc"}, int'(b_mc), mc);
      chk({tag, ".b_tw"}, int'(b_tw), tw);
      chk({tag, ".b_up"}, int'(b_up), up);
      chk({tag, ".b_run"}, int'(b_run), run);
   endtask

   // Inputs change on the falling edge, outputs are sampled on the falling edge.
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One frame: frame_clk high for a cycle (one tick), then low for a cycle.
   task automatic frame(input int n);
      repeat (n) begin
         frame_clk = 1'b1;
         step(1);
         frame_clk = 1'b0;
         step(1);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1; step(1); start = 1'b0;
   endtask

   task automatic pulse_pause();
      pause = 1'b1; step(1); pause = 1'b0;
   endtask

   task automatic pulse_home();
      frog_home = 1'b1; step(1); frog_home = 1'b0;
   endtask

   initial begin
      // Reset low for 2 cycles.
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      chk_a("reset", 440, 440, 440, 200, 0, 0);
      chk_b("reset", 1, 639, 2, 3, 0, 0);

      // IDLE ignores frames, pause and frog_home.
      frame(2);
      pulse_pause();
      pulse_home();
      chk_a("idle_hold", 440, 440, 440, 200, 0, 0);

      // Enter RUN and take one frame.
      pulse_start();
      chk_a("started", 440, 440, 440, 200, 0, 1);
      frame_clk = 1'b1;
      step(1);
      chk_a("first_move", 438, 441, 437, 200, 0, 1);
      chk_b("wrap", 639, 0, 639, 2, 0, 1);
      frame_clk = 1'b0;
      step(1);

      // b: 2 -> 1 -> 0 and TIMEOUT; the final tick still moves the objects.
      frame(1);
      chk_b("tw_one", 637, 1, 636, 1, 0, 1);
      frame(1);
      chk_b("timeout", 635, 2, 633, 0, 1, 0);
      chk_a("three_frames", 434, 443, 431, 200, 0, 1);
      frame(5);
      chk_b("frozen", 635, 2, 633, 0, 1, 0);
      chk_a("eight_frames", 424, 448, 416, 200, 0, 1);

      // 29 ticks keep the bar full, the 30th decrements it.
      frame(21);
      chk_a("twentynine_frames", 382, 469, 353, 200, 0, 1);
      frame(1);
      chk_a("thirty_frames", 380, 470, 350, 199, 0, 1);
      pulse_home();
      chk_a("frog_home", 380, 470, 350, 200, 0, 1);
      chk_b("home_in_timeout", 635, 2, 633, 0, 1, 0);

      // Pause for 10 frames, then resume.
      pulse_pause();
      frame(10);
      chk_a("paused", 380, 470, 350, 200, 0, 0);
      chk_b("pause_in_timeout", 635, 2, 633, 0, 1, 0);
      pulse_pause();
      chk_a("resumed", 380, 470, 350, 200, 0, 1);
      frame(1);
      chk_a("resume_move", 378, 471, 347, 200, 0, 1);

      // pause coinciding with a tick: tick discarded.
      pause = 1'b1; frame_clk = 1'b1;
      step(1);
      pause = 1'b0; frame_clk = 1'b0;
      step(1);
      chk_a("pause_with_tick", 378, 471, 347, 200, 0, 0);
      // frog_home while PAUSED reloads the bar (it is already full; shows no corruption).
      pulse_home();
      chk_a("home_paused", 378, 471, 347, 200, 0, 0);
      pulse_pause();

      // start coinciding with a tick: reload only.
      start = 1'b1; frame_clk = 1'b1;
      step(1);
      start = 1'b0; frame_clk = 1'b0;
      chk_a("start_with_tick", 440, 440, 440, 200, 0, 1);
      chk_b("start_with_tick", 1, 639, 2, 3, 0, 1);
      step(1);

      // frog_home coinciding with a time tick on b: reload wins, motion still applies.
      frog_home = 1'b1; frame_clk = 1'b1;
      step(1);
      frog_home = 1'b0; frame_clk = 1'b0;
      chk_b("home_with_time_tick", 639, 0, 639, 3, 0, 1);
      step(1);
      frame(1);
      chk_b("after_home_tick", 637, 1, 636, 2, 0, 1);
      chk_a("after_home_tick", 436, 442, 434, 200, 0, 1);

      // Reset mid-RUN together with a tick.
      rst_n = 1'b0; frame_clk = 1'b1;
      step(1);
      rst_n = 1'b1; frame_clk = 1'b0;
      chk_a("mid_reset", 440, 440, 440, 200, 0, 0);
      chk_b("mid_reset", 1, 639, 2, 3, 0, 0);
      step(1);
      frame(2);
      chk_a("post_reset_idle", 440, 440, 440, 200, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
